// File: rtl/powmod_mon_ctrl_pkg.sv
// rtl/powmod_mon_ctrl_pkg.sv - shared types and constants for the Montgomery exponentiation sequencer
package powmod_pkg;

  localparam int W_MAX = 1024;
  localparam int OPC_W = 16;
  localparam logic [W_MAX-1:0] ONE_W = W_MAX'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SKIP,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_MBAR,
    OP_XBAR,
    OP_SQR,
    OP_MUL,
    OP_POST
  } op_t;

endpackage

// File: rtl/powmod_mon_ctrl_if.sv
// rtl/powmod_mon_ctrl_if.sv - load/valid handshake bundle between the sequencer and MonPro1024
interface powmod_mon_ctrl_if #(
  parameter int W = 1024
);

  logic         oMpEnable;
  logic         oMpLoad;
  logic [W-1:0] oMpX;
  logic [W-1:0] oMpY;
  logic [W-1:0] oMpN;
  logic [W-1:0] oMpN0;
  logic         iMpValid;
  logic [W-1:0] iMpZ;

  modport master (
    output oMpEnable, oMpLoad, oMpX, oMpY, oMpN, oMpN0,
    input  iMpValid, iMpZ
  );

  modport slave (
    input  oMpEnable, oMpLoad, oMpX, oMpY, oMpN, oMpN0,
    output iMpValid, iMpZ
  );

endinterface

// File: rtl/powmod_mon_ctrl_exp_scan.sv
// rtl/powmod_mon_ctrl_exp_scan.sv - exponent shift register and bit index; leading-zero skip under POWMOD_SKIP_LZ_EN
module powmod_exp_scan #(
  parameter int EW = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          shift_i,
  input  logic [EW-1:0] e_i,
  output logic          bit_o,
  output logic          last_o,
  output logic          none_o,
  output logic          skip_done_o
);

  localparam int IW = $clog2(EW) + 1;

  logic [EW-1:0] e_q;
  logic [IW-1:0] idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q   <= '0;
      idx_q <= '0;
    end else if (load_i) begin
      e_q   <= e_i;
      idx_q <= IW'(EW - 1);
    end else if (shift_i) begin
      e_q   <= {e_q[EW-2:0], 1'b0};
      idx_q <= idx_q - IW'(1);
    end
  end

  assign bit_o  = e_q[EW-1];
  assign last_o = (idx_q == '0);

`ifdef POWMOD_SKIP_LZ_EN
  // After skipping, an all-zero register can only mean the exponent itself was zero.
  assign none_o      = ~|e_q;
  assign skip_done_o = e_q[EW-1] | ~|e_q;
`else
  assign none_o      = 1'b0;
  assign skip_done_o = 1'b1;
`endif

endmodule

// File: rtl/powmod_mon_ctrl.sv
// rtl/powmod_mon_ctrl.sv - Z = M^E mod N sequencer driving one MonPro1024; optional leading-zero skip via POWMOD_SKIP_LZ_EN
module powmod_mon_ctrl
  import powmod_pkg::*;
#(
  parameter int W  = 1024,
  parameter int EW = 1024
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [W-1:0]     iM,
  input  logic [EW-1:0]    iE,
  input  logic [W-1:0]     iN,
  input  logic [W-1:0]     iN0,
  input  logic [W-1:0]     iR2,
  output logic             oBusy,
  output logic             oDone,
  output logic [W-1:0]     oZ,
  output logic [OPC_W-1:0] oOpCount,
  powmod_mon_ctrl_if.master mp
);

  state_t           state_q;
  op_t              op_q, op_d;
  logic [W-1:0]     m_q, n_q, n0_q, r2_q, mbar_q, xbar_q, z_q;
  logic [OPC_W-1:0] opcnt_q;
  logic             busy_q, done_q, en_q, load_q;
  logic [W-1:0]     mp_x, mp_y;

  logic scan_load, scan_shift, cur_bit, last_bit, no_bits, skip_done;

  assign scan_load = (state_q == ST_IDLE) && iStart;

  powmod_exp_scan #(.EW(EW)) u_scan (
    .clk        (iClk),
    .rst        (iRst),
    .load_i     (scan_load),
    .shift_i    (scan_shift),
    .e_i        (iE),
    .bit_o      (cur_bit),
    .last_o     (last_bit),
    .none_o     (no_bits),
    .skip_done_o(skip_done)
  );

  always_comb begin
    op_d = op_q;
    case (op_q)
      OP_MBAR: op_d = OP_XBAR;
      OP_XBAR: op_d = no_bits ? OP_POST : OP_SQR;
      OP_SQR:  op_d = cur_bit ? OP_MUL : (last_bit ? OP_POST : OP_SQR);
      OP_MUL:  op_d = last_bit ? OP_POST : OP_SQR;
      default: op_d = OP_POST;
    endcase
  end

  // Advance to the next exponent bit only when a new SQR follows a finished bit.
  always_comb begin
    scan_shift = 1'b0;
    if (state_q == ST_SKIP && !skip_done) begin
      scan_shift = 1'b1;
    end
    if (state_q == ST_NEXT && op_d == OP_SQR && (op_q == OP_SQR || op_q == OP_MUL)) begin
      scan_shift = 1'b1;
    end
  end

  always_comb begin
    mp_x = m_q;
    mp_y = r2_q;
    case (op_q)
      OP_MBAR: begin mp_x = m_q;    mp_y = r2_q;           end
      OP_XBAR: begin mp_x = r2_q;   mp_y = ONE_W[W-1:0];   end
      OP_SQR:  begin mp_x = xbar_q; mp_y = xbar_q;         end
      OP_MUL:  begin mp_x = mbar_q; mp_y = xbar_q;         end
      default: begin mp_x = xbar_q; mp_y = ONE_W[W-1:0];   end
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MBAR;
      m_q     <= '0;
      n_q     <= '0;
      n0_q    <= '0;
      r2_q    <= '0;
      mbar_q  <= '0;
      xbar_q  <= '0;
      z_q     <= '0;
      opcnt_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (iStart) begin
            m_q     <= iM;
            n_q     <= iN;
            n0_q    <= iN0;
            r2_q    <= iR2;
            opcnt_q <= '0;
            busy_q  <= 1'b1;
            op_q    <= OP_MBAR;
`ifdef POWMOD_SKIP_LZ_EN
            state_q <= ST_SKIP;
`else
            state_q <= ST_ISSUE;
            en_q    <= 1'b1;
            load_q  <= 1'b1;
`endif
          end
        end
        ST_SKIP: begin
          if (skip_done) begin
            state_q <= ST_ISSUE;
            en_q    <= 1'b1;
            load_q  <= 1'b1;
          end
        end
        ST_ISSUE: begin
          load_q  <= 1'b0;
          opcnt_q <= opcnt_q + OPC_W'(1);
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mp.iMpValid) begin
            if (op_q == OP_MBAR) begin
              mbar_q <= mp.iMpZ;
            end else begin
              xbar_q <= mp.iMpZ;
            end
            state_q <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (op_q == OP_POST) begin
            z_q     <= xbar_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            op_q    <= op_d;
            load_q  <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign oBusy        = busy_q;
  assign oDone        = done_q;
  assign oZ           = z_q;
  assign oOpCount     = opcnt_q;
  assign mp.oMpEnable = en_q;
  assign mp.oMpLoad   = load_q;
  assign mp.oMpX      = mp_x;
  assign mp.oMpY      = mp_y;
  assign mp.oMpN      = n_q;
  assign mp.oMpN0     = n0_q;

endmodule

// File: tb/tb_powmod_mon_ctrl.sv
// tb/tb_powmod_mon_ctrl.sv - randomized bench with a behavioural MonPro and modular-exponent reference
module tb_powmod_mon_ctrl;

  localparam int W    = 1024;
  localparam int EW   = 8;
  localparam int NMOD = 187;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          iStart = 1'b0;
  logic [W-1:0]  iM = '0, iN = '0, iN0 = '0, iR2 = '0;
  logic [EW-1:0] iE = '0;
  logic          oBusy, oDone;
  logic [W-1:0]  oZ;
  logic [15:0]   oOpCount;

  powmod_mon_ctrl_if #(.W(W)) mp ();

  powmod_mon_ctrl #(.W(W), .EW(EW)) dut (
    .iClk    (clk),
    .iRst    (rst),
    .iStart  (iStart),
    .iM      (iM),
    .iE      (iE),
    .iN      (iN),
    .iN0     (iN0),
    .iR2     (iR2),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oZ      (oZ),
    .oOpCount(oOpCount),
    .mp      (mp.master)
  );

  always #5 clk = ~clk;

  int           n_tests = 0;
  int           n_fail  = 0;
  longint       rmod, rinv, r2;
  logic [W-1:0] n0_val;
  bit           model_busy = 1'b0;
  bit           spur_en = 1'b1;
  int           load_cnt = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // MonPro(a,b) = a*b*R^-1 mod n, with R^-1 found by search since n is small.
  function automatic longint mp_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [W-1:0] n);
    longint aa, bb, nn;
    aa = longint'(a[31:0]);
    bb = longint'(b[31:0]);
    nn = longint'(n[31:0]);
    if (nn == 0) return 0;
    return (((aa % nn) * (bb % nn)) % nn) * rinv % nn;
  endfunction

  function automatic longint ref_pow(input longint m, input longint e);
    longint r;
    r = 1;
    for (longint i = 0; i < e; i++) r = (r * m) % NMOD;
    return r;
  endfunction

  function automatic int exp_ops(input int e);
    int pc, bl;
    pc = 0;
    bl = 0;
    for (int i = 0; i < EW; i++) begin
      if (e[i]) begin
        pc++;
        bl = i + 1;
      end
    end
`ifndef POWMOD_SKIP_LZ_EN
    bl = EW;
`endif
    return 3 + bl + pc;
  endfunction

  // MonPro behavioural model plus handshake checks.
  initial begin
    logic [W-1:0] x_cap, y_cap;
    int cnt;
    bit prev_load, prev_rv, rv_now;
    mp.iMpValid = 1'b0;
    mp.iMpZ     = '0;
    prev_load   = 1'b0;
    prev_rv     = 1'b0;
    cnt         = 0;
    x_cap       = '0;
    y_cap       = '0;
    forever begin
      @(negedge clk);
      rv_now      = 1'b0;
      mp.iMpValid = 1'b0;
      if (rst || !mp.oMpEnable) begin
        model_busy = 1'b0;
      end else if (mp.oMpLoad) begin
        check("load_pulse", W'(prev_load), '0);
        check("load_gap", W'(prev_rv), '0);
        check("mp_n", mp.oMpN, W'(NMOD));
        check("mp_n0", mp.oMpN0, n0_val);
        x_cap      = mp.oMpX;
        y_cap      = mp.oMpY;
        cnt        = $urandom_range(5, 40);
        model_busy = 1'b1;
        load_cnt++;
      end else if (model_busy) begin
        check("mp_x_stable", mp.oMpX, x_cap);
        check("mp_y_stable", mp.oMpY, y_cap);
        if (cnt == 0) begin
          mp.iMpValid = 1'b1;
          mp.iMpZ     = W'(mp_model(x_cap, y_cap, mp.oMpN));
          model_busy  = 1'b0;
          rv_now      = 1'b1;
        end else begin
          cnt--;
        end
      end else if (prev_rv && spur_en) begin
        mp.iMpValid = 1'b1;
        mp.iMpZ     = W'($urandom_range(1, NMOD - 1));
      end
      prev_load = mp.oMpLoad;
      prev_rv   = rv_now;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    iStart = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
  endtask

  task automatic do_run(input int m, input int e, input bit mid_start);
    longint ez;
    int eo, cyc;
    ez  = ref_pow(longint'(m), longint'(e));
    eo  = exp_ops(e);
    iM  = W'(m);
    iE  = EW'(e);
    iN  = W'(NMOD);
    iN0 = n0_val;
    iR2 = W'(r2);
    pulse_start();
    check("busy_after_start", W'(oBusy), W'(1));
    if (mid_start) begin
      cyc = 0;
      while (!model_busy && cyc < 2000) begin
        @(negedge clk);
        cyc++;
      end
      iM  = W'(2);
      iE  = EW'(10);
      iR2 = W'(5);
      iStart = 1'b1;
      @(negedge clk);
      iStart = 1'b0;
    end
    cyc = 0;
    while (!oDone && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", W'(oDone), W'(1));
    check("z", oZ, W'(ez));
    check("op_count", W'(oOpCount), W'(eo));
    @(negedge clk);
    check("done_pulse", W'(oDone), '0);
    check("z_held", oZ, W'(ez));
    check("busy_clear", W'(oBusy), '0);
    check("enable_off", W'(mp.oMpEnable), '0);
  endtask

  task automatic reset_mid_sqr();
    int base, cyc;
    base = load_cnt;
    iM   = W'(88);
    iE   = EW'(7);
    iN   = W'(NMOD);
    iN0  = n0_val;
    iR2  = W'(r2);
    pulse_start();
    cyc = 0;
    while (!(load_cnt == base + 3 && model_busy && !mp.oMpLoad) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_sqr_wait", W'(cyc < 3000), W'(1));
    rst = 1'b1;
    @(negedge clk);
    check("rst_enable", W'(mp.oMpEnable), '0);
    check("rst_busy", W'(oBusy), '0);
    check("rst_done", W'(oDone), '0);
    check("rst_z", oZ, '0);
    check("rst_opcount", W'(oOpCount), '0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rmod = 1;
    for (int i = 0; i < W; i++) rmod = (rmod * 2) % NMOD;
    rinv = 0;
    for (int k = 1; k < NMOD; k++) if ((rmod * k) % NMOD == 1) rinv = k;
    r2     = (rmod * rmod) % NMOD;
    n0_val = W'({$urandom(), $urandom()});

    repeat (3) @(negedge clk);
    check("reset_busy", W'(oBusy), '0);
    check("reset_done", W'(oDone), '0);
    check("reset_enable", W'(mp.oMpEnable), '0);
    check("reset_load", W'(mp.oMpLoad), '0);
    check("reset_z", oZ, '0);
    check("reset_opcount", W'(oOpCount), '0);
    rst = 1'b0;
    @(negedge clk);

    do_run(88, 7, 1'b0);
    do_run(50, 0, 1'b0);
    do_run(186, 1, 1'b0);
    do_run(88, 7, 1'b1);
    do_run(2, 10, 1'b0);
    reset_mid_sqr();
    do_run(88, 7, 1'b0);
    for (int r = 0; r < 5; r++) begin
      spur_en = 1'($urandom_range(0, 1));
      do_run(int'($urandom_range(0, NMOD - 1)), int'($urandom_range(0, 255)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
